// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: DATA_BITS data bits, optional parity, 1 or 2 stop bits.
// Each bit is sampled at mid-bit using a shared OVERSAMPLE x baud tick enable.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_baud_tick,
    input  logic                 i_rxd,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic                   rxd_m;
    logic                   rxd_s;
    logic                   rxd_d;
    logic [TW-1:0]          tick_cnt;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   par_acc;
    logic                   par_err;
    logic                   fe_acc;
    logic                   frame_done;

    // Synchronizer flops reset to the idle line level so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            rxd_m <= i_rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_acc    <= 1'b0;
            par_err    <= 1'b0;
            fe_acc     <= 1'b0;
            frame_done <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Only a falling edge starts a frame; a line stuck low never re-triggers.
                    if (rxd_d && !rxd_s) begin
                        state    <= S_START;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        par_acc  <= 1'b0;
                        par_err  <= 1'b0;
                        fe_acc   <= 1'b0;
                        o_busy   <= 1'b1;
                    end
                end
                S_START: begin
                    if (i_baud_tick) begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            if (!rxd_s) begin
                                state <= S_DATA;
                            end else begin
                                state  <= S_IDLE;
                                o_busy <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (i_baud_tick) begin
                        if (tick_cnt == TICK_END) begin
                            tick_cnt  <= '0;
                            shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
                            par_acc   <= par_acc ^ rxd_s;
                            if (bit_cnt == LAST_DATA) begin
                                bit_cnt <= '0;
                                state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (i_baud_tick) begin
                        if (tick_cnt == TICK_END) begin
                            tick_cnt <= '0;
                            par_err  <= par_acc ^ rxd_s ^ PAR_ODD;
                            state    <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (i_baud_tick) begin
                        if (tick_cnt == TICK_END) begin
                            tick_cnt <= '0;
                            if (!rxd_s) begin
                                fe_acc <= 1'b1;
                            end
                            // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                            if (bit_cnt == LAST_STOP) begin
                                bit_cnt    <= '0;
                                state      <= S_IDLE;
                                o_busy     <= 1'b0;
                                frame_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_rx_valid   <= 1'b0;
            o_rx_data    <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_rx_valid <= frame_done;
            if (frame_done) begin
                o_rx_data    <= shift_reg;
                o_parity_err <= (PARITY_EN != 0) ? par_err : 1'b0;
                o_frame_err  <= fe_acc;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 8E1, 7N2) sharing clock,
// reset and baud tick (every 4th clk, OVERSAMPLE 16, bit period 64 clk).
module tb_uart_rx_param;

    localparam int BIT_CLKS = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic baud_tick = 1'b0;
    logic line_a = 1'b1;
    logic line_b = 1'b1;
    logic line_c = 1'b1;

    logic [7:0] data_a;
    logic       valid_a, perr_a, ferr_a, busy_a;
    logic [7:0] data_b;
    logic       valid_b, perr_b, ferr_b, busy_b;
    logic [6:0] data_c;
    logic       valid_c, perr_c, ferr_c, busy_c;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int tick_div = 0;
    int cnt_a = 0, cnt_b = 0, cnt_c = 0;
    int t_a_last = 0, t_a_prev = 0, t_c_last = 0, t_c_prev = 0;

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .i_baud_tick(baud_tick), .i_rxd(line_a),
        .o_rx_data(data_a), .o_rx_valid(valid_a), .o_parity_err(perr_a),
        .o_frame_err(ferr_a), .o_busy(busy_a)
    );

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
        .clk(clk), .reset(reset), .i_baud_tick(baud_tick), .i_rxd(line_b),
        .o_rx_data(data_b), .o_rx_valid(valid_b), .o_parity_err(perr_b),
        .o_frame_err(ferr_b), .o_busy(busy_b)
    );

    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_c (
        .clk(clk), .reset(reset), .i_baud_tick(baud_tick), .i_rxd(line_c),
        .o_rx_data(data_c), .o_rx_valid(valid_c), .o_parity_err(perr_c),
        .o_frame_err(ferr_c), .o_busy(busy_c)
    );

    always #5 clk = ~clk;

    // Tick generation and valid-pulse monitors, all on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        tick_div = (tick_div + 1) % 4;
        baud_tick = (tick_div == 0);
        if (valid_a === 1'b1) begin
            cnt_a = cnt_a + 1;
            t_a_prev = t_a_last;
            t_a_last = cyc;
        end
        if (valid_b === 1'b1) cnt_b = cnt_b + 1;
        if (valid_c === 1'b1) begin
            cnt_c = cnt_c + 1;
            t_c_prev = t_c_last;
            t_c_last = cyc;
        end
    end

    task automatic drive_bit(input int which, input logic v, input int n);
        case (which)
            0: line_a = v;
            1: line_b = v;
            default: line_c = v;
        endcase
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input int par_en, input logic par_bit, input int nstop,
                              input logic stop_val);
        drive_bit(which, 1'b0, BIT_CLKS);
        for (int i = 0; i < nbits; i++) drive_bit(which, data[i], BIT_CLKS);
        if (par_en != 0) drive_bit(which, par_bit, BIT_CLKS);
        for (int i = 0; i < nstop; i++) drive_bit(which, stop_val, BIT_CLKS);
    endtask

    task automatic test_reset;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({data_a, valid_a, perr_a, ferr_a, busy_a} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 000", {data_a, valid_a, perr_a, ferr_a, busy_a});
        end
        n_cmp++;
        if ({data_c, busy_c, busy_b} !== 9'h000) begin
            n_bad++;
            $display("FAIL reset_other: got %h expected 000", {data_c, busy_c, busy_b});
        end
    endtask

    task automatic test_basic;
        int c0;
        c0 = cnt_a;
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1);
        n_cmp++;
        if (cnt_a !== c0 + 1) begin
            n_bad++;
            $display("FAIL basic_count: got %0d expected %0d", cnt_a, c0 + 1);
        end
        n_cmp++;
        if (data_a !== 8'hA5) begin
            n_bad++;
            $display("FAIL basic_data: got %h expected a5", data_a);
        end
        n_cmp++;
        if ({perr_a, ferr_a, busy_a} !== 3'b000) begin
            n_bad++;
            $display("FAIL basic_flags: got %b expected 000", {perr_a, ferr_a, busy_a});
        end
    endtask

    task automatic test_glitch;
        int c0;
        c0 = cnt_a;
        drive_bit(0, 1'b0, 8);
        n_cmp++;
        if (busy_a !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_busy_high: got %b expected 1", busy_a);
        end
        drive_bit(0, 1'b0, 4);
        drive_bit(0, 1'b1, 2 * BIT_CLKS);
        n_cmp++;
        if (cnt_a !== c0) begin
            n_bad++;
            $display("FAIL glitch_no_valid: got %0d expected %0d", cnt_a, c0);
        end
        n_cmp++;
        if ({busy_a, data_a} !== {1'b0, 8'hA5}) begin
            n_bad++;
            $display("FAIL glitch_state: got %h expected 0a5", {busy_a, data_a});
        end
    endtask

    task automatic test_parity;
        int c0;
        c0 = cnt_b;
        send_frame(1, 9'h003, 8, 1, 1'b1, 1, 1'b1);
        n_cmp++;
        if ({cnt_b - c0, data_b, perr_b, ferr_b} !== {32'd1, 8'h03, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL parity_bad: got cnt %0d data %h perr %b ferr %b expected 1 03 1 0",
                     cnt_b - c0, data_b, perr_b, ferr_b);
        end
        send_frame(1, 9'h003, 8, 1, 1'b0, 1, 1'b1);
        n_cmp++;
        if ({cnt_b - c0, data_b, perr_b, ferr_b} !== {32'd2, 8'h03, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL parity_good: got cnt %0d data %h perr %b ferr %b expected 2 03 0 0",
                     cnt_b - c0, data_b, perr_b, ferr_b);
        end
        // 0xB7 has six ones, so even parity bit 0 is correct.
        send_frame(1, 9'h0B7, 8, 1, 1'b0, 1, 1'b1);
        n_cmp++;
        if ({data_b, perr_b} !== {8'hB7, 1'b0}) begin
            n_bad++;
            $display("FAIL parity_b7: got %h expected 16e", {data_b, perr_b});
        end
        n_cmp++;
        if (perr_a !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_disabled: got %b expected 0", perr_a);
        end
    endtask

    task automatic test_frame_err;
        int c0;
        c0 = cnt_a;
        send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 1'b0);
        drive_bit(0, 1'b0, 20 * BIT_CLKS);
        n_cmp++;
        if (cnt_a !== c0 + 1) begin
            n_bad++;
            $display("FAIL ferr_count: got %0d expected %0d", cnt_a, c0 + 1);
        end
        n_cmp++;
        if ({data_a, ferr_a, perr_a} !== {8'h5A, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL ferr_flags: got %h expected 5a, ferr 1", {data_a, ferr_a, perr_a});
        end
        drive_bit(0, 1'b1, 2 * BIT_CLKS);
        send_frame(0, 9'h011, 8, 0, 1'b0, 1, 1'b1);
        n_cmp++;
        if ({cnt_a - c0, data_a, ferr_a} !== {32'd2, 8'h11, 1'b0}) begin
            n_bad++;
            $display("FAIL ferr_recover: got cnt %0d data %h ferr %b expected 2 11 0",
                     cnt_a - c0, data_a, ferr_a);
        end
    endtask

    task automatic test_back_to_back;
        int c0;
        c0 = cnt_a;
        send_frame(0, 9'h055, 8, 0, 1'b0, 1, 1'b1);
        n_cmp++;
        if (data_a !== 8'h55) begin
            n_bad++;
            $display("FAIL b2b_first: got %h expected 55", data_a);
        end
        send_frame(0, 9'h0AA, 8, 0, 1'b0, 1, 1'b1);
        n_cmp++;
        if ({cnt_a - c0, data_a} !== {32'd2, 8'hAA}) begin
            n_bad++;
            $display("FAIL b2b_second: got cnt %0d data %h expected 2 aa", cnt_a - c0, data_a);
        end
        n_cmp++;
        if (t_a_last - t_a_prev !== 10 * BIT_CLKS) begin
            n_bad++;
            $display("FAIL b2b_spacing: got %0d expected %0d", t_a_last - t_a_prev, 10 * BIT_CLKS);
        end
        c0 = cnt_c;
        send_frame(2, 9'h07F, 7, 0, 1'b0, 2, 1'b1);
        n_cmp++;
        if ({data_c, ferr_c, perr_c} !== {7'h7F, 2'b00}) begin
            n_bad++;
            $display("FAIL b2b_7n2_first: got %h expected 1fc", {data_c, ferr_c, perr_c});
        end
        send_frame(2, 9'h02A, 7, 0, 1'b0, 2, 1'b1);
        n_cmp++;
        if ({cnt_c - c0, data_c} !== {32'd2, 7'h2A}) begin
            n_bad++;
            $display("FAIL b2b_7n2_second: got cnt %0d data %h expected 2 2a", cnt_c - c0, data_c);
        end
        n_cmp++;
        if (t_c_last - t_c_prev !== 10 * BIT_CLKS) begin
            n_bad++;
            $display("FAIL b2b_7n2_spacing: got %0d expected %0d", t_c_last - t_c_prev, 10 * BIT_CLKS);
        end
    endtask

    task automatic test_mid_reset;
        int c0;
        c0 = cnt_a;
        // 0xC3 LSB first: bits 1,1,0,0,... ; reset lands mid data bit 3.
        drive_bit(0, 1'b0, BIT_CLKS);
        drive_bit(0, 1'b1, BIT_CLKS);
        drive_bit(0, 1'b1, BIT_CLKS);
        drive_bit(0, 1'b0, BIT_CLKS);
        drive_bit(0, 1'b0, BIT_CLKS / 2);
        n_cmp++;
        if (busy_a !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_busy_before: got %b expected 1", busy_a);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        line_a = 1'b1;
        n_cmp++;
        if ({data_a, valid_a, perr_a, ferr_a, busy_a} !== 12'h000) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %h expected 000", {data_a, valid_a, perr_a, ferr_a, busy_a});
        end
        n_cmp++;
        if (data_c !== 7'h00) begin
            n_bad++;
            $display("FAIL mid_reset_other: got %h expected 00", data_c);
        end
        drive_bit(0, 1'b1, 12 * BIT_CLKS);
        n_cmp++;
        if (cnt_a !== c0) begin
            n_bad++;
            $display("FAIL mid_reset_no_valid: got %0d expected %0d", cnt_a, c0);
        end
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1);
        n_cmp++;
        if ({cnt_a - c0, data_a, ferr_a} !== {32'd1, 8'h3C, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_reset_next: got cnt %0d data %h ferr %b expected 1 3c 0",
                     cnt_a - c0, data_a, ferr_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_frame_err();
        test_back_to_back();
        test_mid_reset();
        drive_bit(0, 1'b1, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
